tx232_pd_fifo: RTL and testbench

//  UART-style serial transmitter with FIFO; transmit partner of the rx232 receive path.

---
 rtl/tx232_pd_fifo.sv | 162 ++++++++++++++++
 tb/tb_tx232_pd_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx232_pd_fifo.sv
// tx232_pd_fifo: FIFO-fed serial transmitter, 8N + STOP_BITS frames.
// One line bit per rising edge of the external bit clock txck.
module tx232_pd_fifo #(
  parameter int DEPTH     = 4,
  parameter int STOP_BITS = 2,
  parameter int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             txck,
  input  logic [7:0]       txpd,
  input  logic             txwr,
  output logic             txsd,
  output logic             txbusy,
  output logic             txfull,
  output logic             txempty,
  output logic [LVL_W-1:0] txlvl,
  output logic             txovf,
  output logic             tx_start,
  output logic             txdone
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [1:0]      txck_d;
  logic            tick;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LVL_W-1:0] lvl_nxt;
  logic            push;
  logic            pop;
  logic            frame_end;
  logic [7:0]      sh;
  logic [2:0]      bit_cnt;
  logic [1:0]      stop_cnt;

  // txck is asynchronous; the rising edge becomes a single clk tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txck_d <= 2'b00;
    end else begin
      txck_d <= {txck_d[0], txck};
    end
  end

  assign tick = txck_d[0] & ~txck_d[1];

  assign frame_end = (state == STOP) && (stop_cnt == STOP_LAST);
  assign push      = txwr & ~txfull;
  assign pop       = tick & ~txempty & ((state == IDLE) | frame_end);
  assign lvl_nxt   = txlvl + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= txpd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      txlvl   <= '0;
      txfull  <= 1'b0;
      txempty <= 1'b1;
      txovf   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      txlvl   <= lvl_nxt;
      txfull  <= (lvl_nxt == LVL_FULL);
      txempty <= (lvl_nxt == '0);
      txovf   <= txwr & txfull;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      txsd     <= 1'b1;
      txbusy   <= 1'b0;
      tx_start <= 1'b0;
      txdone   <= 1'b0;
      sh       <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      txdone   <= 1'b0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (pop) begin
              sh       <= mem[rd_ptr];
              txsd     <= 1'b0;
              tx_start <= 1'b1;
              txbusy   <= 1'b1;
              state    <= START;
            end else begin
              txsd <= 1'b1;
            end
          end
          START: begin
            txsd    <= sh[0];
            sh      <= {1'b0, sh[7:1]};
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt == 3'd7) begin
              txsd     <= 1'b1;
              stop_cnt <= '0;
              state    <= STOP;
            end else begin
              txsd    <= sh[0];
              sh      <= {1'b0, sh[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          STOP: begin
            if (frame_end) begin
              txdone <= 1'b1;
              // next queued byte starts with no idle bit-time in between
              if (pop) begin
                sh       <= mem[rd_ptr];
                txsd     <= 1'b0;
                tx_start <= 1'b1;
                state    <= START;
              end else begin
                txsd   <= 1'b1;
                txbusy <= 1'b0;
                state  <= IDLE;
              end
            end else begin
              txsd     <= 1'b1;
              stop_cnt <= stop_cnt + 2'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx232_pd_fifo.sv
// tb_tx232_pd_fifo: directed vectors for the FIFO serial transmitter.
// Bit clock is driven slowly relative to clk; outputs sampled on negedge.
module tb_tx232_pd_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       txck = 1'b0;
  logic [7:0] txpd = '0;
  logic       txwr = 1'b0;
  logic       txsd;
  logic       txbusy;
  logic       txfull;
  logic       txempty;
  logic [2:0] txlvl;
  logic       txovf;
  logic       tx_start;
  logic       txdone;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_done  = 0;
  int n_ovf   = 0;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  vec_t tv [6];

  tx232_pd_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .txck     (txck),
    .txpd     (txpd),
    .txwr     (txwr),
    .txsd     (txsd),
    .txbusy   (txbusy),
    .txfull   (txfull),
    .txempty  (txempty),
    .txlvl    (txlvl),
    .txovf    (txovf),
    .tx_start (tx_start),
    .txdone   (txdone)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start) n_start++;
    if (txdone) n_done++;
    if (txovf) n_ovf++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    txpd = d;
    txwr = 1'b1;
    @(negedge clk);
    txwr = 1'b0;
  endtask

  task automatic tick_bit(output logic sd, output logic busy);
    @(negedge clk);
    txck = 1'b1;
    repeat (3) @(negedge clk);
    sd   = txsd;
    busy = txbusy;
    txck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(output logic [10:0] bits, output int busy_n);
    logic sd;
    logic b;
    busy_n = 0;
    for (int i = 0; i < 11; i++) begin
      tick_bit(sd, b);
      bits[i] = sd;
      busy_n += int'(b);
    end
  endtask

  initial begin
    logic [10:0] bits;
    logic [10:0] bits2;
    int          bn;
    int          s0;
    int          d0;
    int          o0;
    logic        sd;
    logic        b;

    tv[0] = '{8'hA5, 11'b11101001010};
    tv[1] = '{8'h00, 11'b11000000000};
    tv[2] = '{8'hFF, 11'b11111111110};
    tv[3] = '{8'h3C, 11'b11001111000};
    tv[4] = '{8'h81, 11'b11100000010};
    tv[5] = '{8'h5A, 11'b11010110100};

    // reset held while inputs toggle
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      txwr = i[0];
      txck = i[1];
      txpd = 8'(i);
    end
    txwr = 1'b0;
    txck = 1'b0;
    chk("rst_txsd", 32'(txsd), 32'd1);
    chk("rst_empty", 32'(txempty), 32'd1);
    chk("rst_lvl", 32'(txlvl), 32'd0);
    chk("rst_busy", 32'(txbusy), 32'd0);
    chk("rst_pulses", 32'(n_start + n_done + n_ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single frames from the table
    for (int v = 0; v < 6; v++) begin
      s0 = n_start;
      d0 = n_done;
      push(tv[v].data);
      chk($sformatf("v%0d_lvl", v), 32'(txlvl), 32'd1);
      run_frame(bits, bn);
      chk($sformatf("v%0d_frame", v), 32'(bits), 32'(tv[v].frame));
      chk($sformatf("v%0d_busy", v), 32'(bn), 32'd11);
      tick_bit(sd, b);
      chk($sformatf("v%0d_idle", v), {30'd0, sd, b}, 32'b10);
      chk($sformatf("v%0d_pulses", v),
          32'((n_start - s0) * 16 + (n_done - d0)), 32'h11);
      chk($sformatf("v%0d_empty", v), 32'(txempty), 32'd1);
    end

    // back-to-back frames, receiver decode
    push(8'h00);
    push(8'hFF);
    run_frame(bits, bn);
    run_frame(bits2, bn);
    chk("b2b_f0", 32'(bits), 32'(tv[1].frame));
    chk("b2b_f1", 32'(bits2), 32'(tv[2].frame));
    chk("b2b_rx0", {21'd0, bits[10:9], bits[0], bits[8:1]}, {21'd0, 3'b110, 8'h00});
    chk("b2b_rx1", {21'd0, bits2[10:9], bits2[0], bits2[8:1]}, {21'd0, 3'b110, 8'hFF});
    tick_bit(sd, b);
    chk("b2b_idle", {30'd0, sd, b}, 32'b10);

    // overflow with no ticks
    o0 = n_ovf;
    push(tv[4].data);
    push(tv[5].data);
    push(tv[3].data);
    push(tv[0].data);
    chk("ovf_lvl4", 32'(txlvl), 32'd4);
    chk("ovf_full", 32'(txfull), 32'd1);
    chk("ovf_nopulse", 32'(n_ovf - o0), 32'd0);
    push(8'h00);
    chk("ovf_pulse", 32'(txovf), 32'd1);
    chk("ovf_lvl_hold", 32'(txlvl), 32'd4);
    run_frame(bits, bn);
    chk("ovf_f0", 32'(bits), 32'(tv[4].frame));
    run_frame(bits, bn);
    chk("ovf_f1", 32'(bits), 32'(tv[5].frame));
    run_frame(bits, bn);
    chk("ovf_f2", 32'(bits), 32'(tv[3].frame));
    run_frame(bits, bn);
    chk("ovf_f3", 32'(bits), 32'(tv[0].frame));
    tick_bit(sd, b);
    chk("ovf_drained", {29'd0, sd, b, txempty}, 32'b101);

    // push coincident with pop tick while full
    for (int i = 0; i < 4; i++) push(tv[i].data);
    chk("pp_full", 32'(txfull), 32'd1);
    @(negedge clk);
    txck = 1'b1;
    @(negedge clk);
    txpd = 8'h77;
    txwr = 1'b1;
    @(negedge clk);
    txwr = 1'b0;
    chk("pp_ovf", 32'(txovf), 32'd1);
    chk("pp_lvl", 32'(txlvl), 32'd3);
    chk("pp_start", 32'(tx_start), 32'd1);
    txck = 1'b0;
    repeat (4) @(negedge clk);

    // reset mid-frame after d3
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push(8'h3C);
    push(8'h81);
    for (int i = 0; i < 5; i++) tick_bit(sd, b);
    chk("mid_d3", 32'(sd), 32'd1);
    tick_bit(sd, b);
    chk("mid_d4", 32'(sd), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst", {28'd0, txsd, txempty, txbusy, txfull}, 32'b1100);
    chk("mid_lvl", 32'(txlvl), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push(8'h5A);
    run_frame(bits, bn);
    chk("mid_clean", 32'(bits), 32'(tv[5].frame));
    tick_bit(sd, b);
    chk("mid_idle", {29'd0, sd, b, txempty}, 32'b101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
